// File: rtl/touch_sample_filter.sv
// Pen-down sample averager for the touchscreen ADC: averages 2**LOG2_AVG samples,
// rejects noisy windows by per-axis spread, and emits one point per accepted window.
module touch_sample_filter #(
  parameter int LOG2_AVG   = 2,
  parameter int MAX_SPREAD = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        pen_down,
  input  logic        sample_valid,
  input  logic [11:0] x_raw,
  input  logic [11:0] y_raw,
  output logic        pos_ready,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        touching,
  output logic [7:0]  reject_cnt
);

  localparam int SUM_W = 12 + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_AVG) - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [11:0]        min_x_q, min_x_d, max_x_q, max_x_d;
  logic [11:0]        min_y_q, min_y_d, max_y_q, max_y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [11:0]        x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic [7:0]         reject_cnt_q, reject_cnt_d;
  logic               pos_ready_q, pos_ready_d;
  logic               touching_q, touching_d;

  logic [SUM_W-1:0]   nx_sum_x, nx_sum_y;
  logic [11:0]        nx_min_x, nx_max_x, nx_min_y, nx_max_y;
  logic               clr_win;

  function automatic logic [11:0] avg_trunc(input logic [SUM_W-1:0] sum);
    avg_trunc = 12'(sum >> LOG2_AVG);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic spread_ok(input logic [11:0] mx, input logic [11:0] mn);
    logic [12:0] d;
    d = {1'b0, mx} - {1'b0, mn};
    spread_ok = (d <= 13'(MAX_SPREAD));
  endfunction

  // Window contents as they would be after absorbing the current sample
  always_comb begin
    nx_sum_x = sum_x_q + SUM_W'(x_raw);
    nx_sum_y = sum_y_q + SUM_W'(y_raw);
    nx_min_x = (x_raw < min_x_q) ? x_raw : min_x_q;
    nx_max_x = (x_raw > max_x_q) ? x_raw : max_x_q;
    nx_min_y = (y_raw < min_y_q) ? y_raw : min_y_q;
    nx_max_y = (y_raw > max_y_q) ? y_raw : max_y_q;
  end

  always_comb begin
    state_d      = state_q;
    sum_x_d      = sum_x_q;
    sum_y_d      = sum_y_q;
    min_x_d      = min_x_q;
    max_x_d      = max_x_q;
    min_y_d      = min_y_q;
    max_y_d      = max_y_q;
    cnt_d        = cnt_q;
    x_pos_d      = x_pos_q;
    y_pos_d      = y_pos_q;
    reject_cnt_d = reject_cnt_q;
    clr_win      = 1'b0;

    case (state_q)
      IDLE: begin
        clr_win = 1'b1;
        if (en && pen_down) state_d = ACCUM;
      end
      ACCUM: begin
        // Pen lift / disable wins over a coincident sample
        if (!en || !pen_down) begin
          clr_win = 1'b1;
          state_d = IDLE;
        end else if (sample_valid) begin
          if (cnt_q == LAST_CNT) begin
            clr_win = 1'b1;
            if (spread_ok(nx_max_x, nx_min_x) && spread_ok(nx_max_y, nx_min_y)) begin
              x_pos_d = avg_trunc(nx_sum_x);
              y_pos_d = avg_trunc(nx_sum_y);
              state_d = EMIT;
            end else begin
              reject_cnt_d = sat_inc8(reject_cnt_q);
            end
          end else begin
            sum_x_d = nx_sum_x;
            sum_y_d = nx_sum_y;
            min_x_d = nx_min_x;
            max_x_d = nx_max_x;
            min_y_d = nx_min_y;
            max_y_d = nx_max_y;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      EMIT: begin
        clr_win = 1'b1;
        state_d = (en && pen_down) ? ACCUM : IDLE;
      end
      default: begin
        clr_win = 1'b1;
        state_d = IDLE;
      end
    endcase

    if (clr_win) begin
      sum_x_d = '0;
      sum_y_d = '0;
      min_x_d = 12'hFFF;
      max_x_d = 12'h000;
      min_y_d = 12'hFFF;
      max_y_d = 12'h000;
      cnt_d   = '0;
    end

    pos_ready_d = (state_d == EMIT);
    touching_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sum_x_q      <= '0;
      sum_y_q      <= '0;
      min_x_q      <= 12'hFFF;
      max_x_q      <= 12'h000;
      min_y_q      <= 12'hFFF;
      max_y_q      <= 12'h000;
      cnt_q        <= '0;
      x_pos_q      <= '0;
      y_pos_q      <= '0;
      reject_cnt_q <= '0;
      pos_ready_q  <= 1'b0;
      touching_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_x_q      <= sum_x_d;
      sum_y_q      <= sum_y_d;
      min_x_q      <= min_x_d;
      max_x_q      <= max_x_d;
      min_y_q      <= min_y_d;
      max_y_q      <= max_y_d;
      cnt_q        <= cnt_d;
      x_pos_q      <= x_pos_d;
      y_pos_q      <= y_pos_d;
      reject_cnt_q <= reject_cnt_d;
      pos_ready_q  <= pos_ready_d;
      touching_q   <= touching_d;
    end
  end

  assign pos_ready  = pos_ready_q;
  assign x_pos      = x_pos_q;
  assign y_pos      = y_pos_q;
  assign touching   = touching_q;
  assign reject_cnt = reject_cnt_q;

endmodule

// File: tb/tb_touch_sample_filter.sv
// Directed bench for touch_sample_filter (LOG2_AVG=2, MAX_SPREAD=64).
module tb_touch_sample_filter;

  logic        clk = 1'b0;
  logic        reset, en, pen_down, sample_valid;
  logic [11:0] x_raw, y_raw;
  logic        pos_ready, touching;
  logic [11:0] x_pos, y_pos;
  logic [7:0]  reject_cnt;

  int checks = 0;
  int fails  = 0;
  int pulses = 0;
  int dbl    = 0;
  logic prev_pr = 1'b0;
  int p0;

  touch_sample_filter #(.LOG2_AVG(2), .MAX_SPREAD(64)) dut (
    .clk(clk), .reset(reset), .en(en), .pen_down(pen_down),
    .sample_valid(sample_valid), .x_raw(x_raw), .y_raw(y_raw),
    .pos_ready(pos_ready), .x_pos(x_pos), .y_pos(y_pos),
    .touching(touching), .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts pos_ready pulses and back-to-back highs
  always @(posedge clk) begin
    if (pos_ready) pulses++;
    if (pos_ready && prev_pr) dbl++;
    prev_pr = pos_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [11:0] x, input logic [11:0] y);
    sample_valid = 1'b1;
    x_raw        = x;
    y_raw        = y;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic send4(input logic [11:0] xa, xb, xc, xd, ya, yb, yc, yd);
    send(xa, ya); idle(1);
    send(xb, yb); idle(1);
    send(xc, yc); idle(1);
    send(xd, yd);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; pen_down = 1'b0; sample_valid = 1'b0;
    x_raw = '0; y_raw = '0;

    // 1. reset values
    idle(4);
    chk("rst_pr", pos_ready, 0);
    chk("rst_x", x_pos, 0);
    chk("rst_y", y_pos, 0);
    chk("rst_touch", touching, 0);
    chk("rst_rej", reject_cnt, 0);

    // 2. accepted window, truncating average
    reset = 1'b0; en = 1'b1; pen_down = 1'b1;
    idle(2);
    chk("press_touch", touching, 1);
    p0 = pulses;
    send(100, 200); idle(3);
    send(101, 200); idle(3);
    send(102, 200); idle(3);
    send(103, 200);
    chk("acc_pr", pos_ready, 1);
    chk("acc_x", x_pos, 101);
    chk("acc_y", y_pos, 200);
    idle(1);
    chk("acc_pr_low", pos_ready, 0);
    chk("acc_touch", touching, 1);
    idle(2);
    chk("acc_pulses", pulses - p0, 1);

    // 3. spread reject then clean window
    send4(100, 100, 100, 300, 200, 200, 200, 200);
    chk("rej_pr", pos_ready, 0);
    chk("rej_cnt", reject_cnt, 1);
    chk("rej_x_held", x_pos, 101);
    idle(1);
    send4(500, 500, 500, 500, 300, 300, 300, 300);
    chk("clean_pr", pos_ready, 1);
    chk("clean_x", x_pos, 500);
    chk("clean_y", y_pos, 300);
    idle(2);

    // spread boundary: 64 accepted, 65 rejected on either axis
    send4(0, 64, 0, 64, 10, 10, 10, 10);
    chk("sp64_pr", pos_ready, 1);
    chk("sp64_x", x_pos, 32);
    idle(2);
    send4(0, 65, 0, 65, 10, 10, 10, 10);
    chk("sp65x_pr", pos_ready, 0);
    chk("sp65x_rej", reject_cnt, 2);
    idle(1);
    send4(50, 50, 50, 50, 0, 0, 0, 65);
    chk("sp65y_pr", pos_ready, 0);
    chk("sp65y_rej", reject_cnt, 3);
    idle(1);

    // 4. pen lift mid-window, then full-scale window
    p0 = pulses;
    send(7, 7); idle(1);
    send(9, 9); idle(1);
    pen_down = 1'b0;
    idle(1);
    chk("lift_touch", touching, 0);
    idle(2);
    chk("lift_pulses", pulses - p0, 0);
    chk("lift_x_held", x_pos, 32);
    pen_down = 1'b1;
    idle(2);
    chk("repress_touch", touching, 1);
    send4(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 0, 0, 0, 0);
    chk("fs_pr", pos_ready, 1);
    chk("fs_x", x_pos, 12'hFFF);
    chk("fs_y", y_pos, 0);

    // sample arriving in the EMIT cycle must not enter the next window
    idle(2);
    send4(800, 800, 800, 800, 800, 800, 800, 800);
    chk("emit1_pr", pos_ready, 1);
    send(0, 0);
    idle(1);
    send(600, 600); idle(1);
    send(600, 600); idle(1);
    send(600, 600);
    chk("emit_skip_pr", pos_ready, 0);
    chk("emit_skip_rej", reject_cnt, 3);
    idle(1);
    send(600, 600);
    chk("emit2_pr", pos_ready, 1);
    chk("emit2_x", x_pos, 600);
    idle(2);

    // 5. continuous stream, then reset mid-window
    p0 = pulses;
    for (int i = 0; i < 12; i++) begin
      send(200, 200);
      idle(7);
    end
    chk("stream_pulses", pulses - p0, 3);
    chk("stream_x", x_pos, 200);
    send(1, 1); idle(7);
    send(1, 1); idle(2);
    reset = 1'b1;
    idle(2);
    chk("mrst_pr", pos_ready, 0);
    chk("mrst_x", x_pos, 0);
    chk("mrst_y", y_pos, 0);
    chk("mrst_touch", touching, 0);
    chk("mrst_rej", reject_cnt, 0);
    reset = 1'b0;
    idle(10);
    chk("mrst_pulses", pulses - p0, 3);

    // 6a. en low during ACCUM discards the partial window
    p0 = pulses;
    send(5, 5); idle(1);
    send(6, 6); idle(1);
    en = 1'b0;
    idle(1);
    chk("en_touch", touching, 0);
    send(1000, 1000);
    idle(2);
    chk("en_touch2", touching, 0);
    chk("en_pulses", pulses - p0, 0);
    en = 1'b1;
    idle(2);
    send4(40, 40, 40, 40, 41, 41, 41, 41);
    chk("en_pr", pos_ready, 1);
    chk("en_x", x_pos, 40);
    chk("en_y", y_pos, 41);
    idle(2);

    // 6b. reject counter saturation
    for (int i = 0; i < 254; i++) begin
      send4(0, 0, 0, 1000, 0, 0, 0, 0);
      idle(1);
    end
    chk("rej_254", reject_cnt, 254);
    for (int i = 0; i < 46; i++) begin
      send4(0, 0, 0, 1000, 0, 0, 0, 0);
      idle(1);
    end
    chk("rej_sat", reject_cnt, 255);
    chk("no_double_pulse", dbl, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
